// File: rtl/lift_scheduler.sv
// lift_scheduler: four-floor SCAN lift controller; door_hold input added when LIFT_DOOR_HOLD_EN is defined
module lift_scheduler #(
    parameter int MOVE_CYCLES = 8,
    parameter int DOOR_CYCLES = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
`ifdef LIFT_DOOR_HOLD_EN
    input  logic       door_hold,
`endif
    output logic [3:0] pos,
    output logic [3:0] pending,
    output logic       moving_up,
    output logic       moving_dn,
    output logic       door_open
);
    localparam int MAXC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_CYCLES - 1);
    localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR} state_t;
    state_t state, state_n, pick;
    logic [3:0] pos_n, pending_n, eff, npos, clr;
    logic [CW-1:0] cnt, cnt_n;
    logic dir, dir_n, hold, here, up_any, dn_any, arr_here, arr_ahead;
`ifdef LIFT_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif
    // next-state: SCAN choice, travel/door timing, call latching and clearing
    always_comb begin
        eff = pending | (req & ~((state == DOOR) ? pos : 4'b0000));
        here = |(eff & pos);
        up_any = |(eff & ~(pos | (pos - 4'd1)));
        dn_any = |(eff & (pos - 4'd1));
        pick = here ? DOOR :
               dir ? (up_any ? MOVE_UP : dn_any ? MOVE_DN : IDLE) :
                     (dn_any ? MOVE_DN : up_any ? MOVE_UP : IDLE);
        npos = (state == MOVE_UP) ? {pos[2:0], 1'b0} : {1'b0, pos[3:1]};
        arr_here = |(eff & npos);
        arr_ahead = (state == MOVE_UP) ? |(eff & ~(npos | (npos - 4'd1))) : |(eff & (npos - 4'd1));
        state_n = state;
        pos_n = pos;
        cnt_n = cnt + CW'(1);
        case (state)
            IDLE: begin
                state_n = pick;
                cnt_n = '0;
            end
            MOVE_UP, MOVE_DN: if (cnt == MOVE_LAST) begin
                pos_n = npos;
                state_n = arr_here ? DOOR : arr_ahead ? state : IDLE;
                cnt_n = '0;
            end
            default: if (hold || |(req & pos)) begin
                cnt_n = '0;
            end else if (cnt == DOOR_LAST) begin
                state_n = pick;
                cnt_n = '0;
            end
        endcase
        dir_n = (state_n == MOVE_UP) ? 1'b1 : (state_n == MOVE_DN) ? 1'b0 : dir;
        clr = (state_n == DOOR && state != DOOR) ? pos_n : 4'b0000;
        pending_n = eff & ~clr;
    end
    // state, position, calls and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pos <= 4'b0001;
            pending <= 4'b0000;
            dir <= 1'b1;
            cnt <= '0;
            moving_up <= 1'b0;
            moving_dn <= 1'b0;
            door_open <= 1'b0;
        end else begin
            state <= state_n;
            pos <= pos_n;
            pending <= pending_n;
            dir <= dir_n;
            cnt <= cnt_n;
            moving_up <= state_n == MOVE_UP;
            moving_dn <= state_n == MOVE_DN;
            door_open <= state_n == DOOR;
        end
    end
endmodule

// File: tb/tb_lift_scheduler.sv
// tb_lift_scheduler: directed scenarios checked against a floor-level behavioural model plus literal expectations
module tb_lift_scheduler;
    localparam int MV = 4, DR = 3;
    logic clk = 1'b0, rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] pos, pending;
    logic moving_up, moving_dn, door_open, mh;
    int compared = 0, failed = 0;
`ifdef LIFT_DOOR_HOLD_EN
    logic door_hold = 1'b0;
    assign mh = door_hold;
`else
    assign mh = 1'b0;
`endif

    always #5 clk = ~clk;

    lift_scheduler #(.MOVE_CYCLES(MV), .DOOR_CYCLES(DR)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
`ifdef LIFT_DOOR_HOLD_EN
        .door_hold(door_hold),
`endif
        .pos(pos),
        .pending(pending),
        .moving_up(moving_up),
        .moving_dn(moving_dn),
        .door_open(door_open)
    );

    // model: floor index 0..3, mode 0 idle / 1 up / 2 down / 3 door, time spent in current phase
    int mf = 0, mm = 0, mt = 0, nm;
    bit mu = 1'b1;
    logic [3:0] mp = 4'b0000, c;

    function automatic bit ahead(logic [3:0] calls, int f, bit up);
        for (int i = 0; i < 4; i++)
            if (calls[i] && (up ? i > f : i < f)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int choose(logic [3:0] calls, int f, bit up);
        if (calls[f]) return 3;
        if (up) return ahead(calls, f, 1'b1) ? 1 : ahead(calls, f, 1'b0) ? 2 : 0;
        return ahead(calls, f, 1'b0) ? 2 : ahead(calls, f, 1'b1) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mf = 0; mm = 0; mt = 0; mu = 1'b1; mp = 4'b0000;
        end else begin
            c = mp | req;
            if (mm == 3) c[mf] = mp[mf];
            nm = mm;
            if (mm == 0) nm = choose(c, mf, mu);
            else if (mm == 3) begin
                if (req[mf] || mh) mt = 0;
                else begin
                    mt++;
                    if (mt == DR) nm = choose(c, mf, mu);
                end
            end else begin
                mt++;
                if (mt == MV) begin
                    mf += (mm == 1) ? 1 : -1;
                    mt = 0;
                    nm = c[mf] ? 3 : ahead(c, mf, mm == 1) ? mm : 0;
                end
            end
            if (nm != mm) begin
                mt = 0;
                if (nm == 3) c[mf] = 1'b0;
                if (nm == 1) mu = 1'b1;
                if (nm == 2) mu = 1'b0;
            end
            mm = nm;
            mp = c;
        end
    end

    // every cycle: DUT outputs against the model
    always @(negedge clk) begin
        logic [3:0] ep;
        ep = 4'b0001 << mf;
        compared++;
        if ({pos, pending, moving_up, moving_dn, door_open} !== {ep, mp, mm == 1, mm == 2, mm == 3}) begin
            failed++;
            $display("FAIL model t=%0t got pos=%b pend=%b up/dn/door=%b%b%b want pos=%b pend=%b up/dn/door=%b%b%b",
                     $time, pos, pending, moving_up, moving_dn, door_open, ep, mp, mm == 1, mm == 2, mm == 3);
        end
    end

    task automatic lit(string name, logic [3:0] got, logic [3:0] exp);
        compared++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s t=%0t got %b want %b", name, $time, got, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] fl();
        return {1'b0, moving_up, moving_dn, door_open};
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        step(2);
        lit("rst_pos", pos, 4'b0001);
        lit("rst_pend", pending, 4'b0000);
        lit("rst_flags", fl(), 4'b0000);
        // call at F1 on the first edge after release
        rst_n = 1'b1; req = 4'b0001;
        step(1); req = 4'b0000;
        lit("f1_door", fl(), 4'b0001);
        lit("f1_pend", pending, 4'b0000);
        lit("f1_pos", pos, 4'b0001);
        step(2); lit("f1_door3", fl(), 4'b0001);
        step(1); lit("f1_close", fl(), 4'b0000);
        // holding the F1 button reloads the door timer
        req = 4'b0001;
        step(5); req = 4'b0000;
        lit("reload_open", fl(), 4'b0001);
        step(2); lit("reload_last", fl(), 4'b0001);
        step(1); lit("reload_close", fl(), 4'b0000);
        lit("reload_pend", pending, 4'b0000);
        // F1 -> F4
        req = 4'b1000;
        step(1); req = 4'b0000;
        lit("up_flag", fl(), 4'b0100);
        lit("up_pend", pending, 4'b1000);
        step(4); lit("up_f2", pos, 4'b0010);
        step(4); lit("up_f3", pos, 4'b0100);
        step(4); lit("up_f4", pos, 4'b1000);
        lit("up_f4_door", fl(), 4'b0001);
        lit("up_f4_pend", pending, 4'b0000);
        step(2); lit("up_f4_door3", fl(), 4'b0001);
        step(1); lit("up_idle", fl(), 4'b0000);
        // reset, then abandon a move between F2 and F3
        #3 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1; req = 4'b1000;
        step(1); req = 4'b0000;
        step(6); lit("mid_pos", pos, 4'b0010);
        #3 rst_n = 1'b0;
        #1 lit("abort_pos", pos, 4'b0001);
        lit("abort_pend", pending, 4'b0000);
        lit("abort_flags", fl(), 4'b0000);
        // new call mid-move is served on the way up
        @(negedge clk) rst_n = 1'b1; req = 4'b1000;
        step(1); req = 4'b0000;
        step(5); lit("scan_f2", pos, 4'b0010);
        req = 4'b0100;
        step(1); req = 4'b0000;
        step(2); lit("scan_f3", pos, 4'b0100);
        lit("scan_f3_door", fl(), 4'b0001);
        lit("scan_f3_pend", pending, 4'b1000);
        step(3); lit("scan_resume", fl(), 4'b0100);
        step(4); lit("scan_f4", pos, 4'b1000);
        lit("scan_f4_door", fl(), 4'b0001);
        step(3); lit("scan_idle", fl(), 4'b0000);
        // at F3 going up with calls 1001: F4 first, then reverse to F1
        #3 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1; req = 4'b0100;
        step(1); req = 4'b0000;
        step(8); lit("rev_f3_door", fl(), 4'b0001);
        req = 4'b1001;
        step(1); req = 4'b0000;
        lit("rev_pend", pending, 4'b1001);
        step(2); lit("rev_up", fl(), 4'b0100);
        step(4); lit("rev_f4", pos, 4'b1000);
        lit("rev_f4_pend", pending, 4'b0001);
        step(3); lit("rev_dn", fl(), 4'b0010);
        step(12); lit("rev_f1", pos, 4'b0001);
        lit("rev_f1_door", fl(), 4'b0001);
        lit("rev_f1_pend", pending, 4'b0000);
        step(3); lit("rev_idle", fl(), 4'b0000);
`ifdef LIFT_DOOR_HOLD_EN
        req = 4'b0001;
        step(1); req = 4'b0000; door_hold = 1'b1;
        step(10); door_hold = 1'b0;
        lit("hold_open", fl(), 4'b0001);
        step(2); lit("hold_last", fl(), 4'b0001);
        step(1); lit("hold_close", fl(), 4'b0000);
`endif
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
